vout_ds18b20: RTL and testbench

VOUT_DS18B20 -- requirements
Module: vout_ds18b20

---
 rtl/vout_ds18b20.sv | 211 +++++++++++++++++++++
 tb/tb_vout_ds18b20.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vout_ds18b20.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vout_ds18b20                                              |
// | Purpose  : DS18B20 1-Wire slave model (Skip ROM, Convert T, Read      |
// |            Scratchpad). Define VOUT_DS18B20_CRC_EN for CRC in byte 8. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module vout_ds18b20 #(
  parameter int TICK_DIV = 48
) (
  input  logic               clk,
  input  logic               reset_n,
  inout  wire                one_wire,
  input  logic signed [15:0] temperature,
  output logic [7:0]         last_cmd,
  output logic               cmd_err
);

  localparam int                 c_PRE_W   = $clog2(TICK_DIV);
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRES_WAIT, S_PRES, S_RX_ROM, S_RX_FUNC, S_CONV, S_TX
  } state_t;

  logic               r_meta, r_sync, r_sync_d;
  logic               w_fall, w_rise;
  logic [c_PRE_W-1:0] r_pre;
  logic               w_us_tick;
  logic [9:0]         r_low;
  logic               w_bus_reset;
  state_t             r_state;
  logic [6:0]         r_us;
  logic               r_slot, r_drive, w_slot_end;
  logic [2:0]         r_bit;
  logic [3:0]         r_byte;
  logic [7:0]         r_shift, r_sp0, r_sp1;
  logic [7:0]         w_tx_byte, w_byte8, w_rx_byte;
  logic               w_tx_bit;

  // Release is gated by reset_n so the bus floats the instant reset asserts.
  assign one_wire = (r_drive && reset_n) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_meta   <= one_wire;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign w_fall    = r_sync_d & ~r_sync;
  assign w_rise    = ~r_sync_d & r_sync;
  assign w_us_tick = (r_pre == c_PRE_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_pre <= '0;
    else if (w_us_tick) r_pre <= '0;
    else                r_pre <= r_pre + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                         r_low <= '0;
    else if (w_fall)                                      r_low <= '0;
    else if (w_us_tick && !r_sync && r_low != 10'd1023)   r_low <= r_low + 10'd1;
  end

  assign w_bus_reset = w_rise && (r_low >= 10'd480);
  assign w_slot_end  = r_slot && w_us_tick && (r_us == 7'd29);
  assign w_rx_byte   = {r_sync, r_shift[7:1]};

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_byte)
      4'd0:    w_tx_byte = r_sp0;
      4'd1:    w_tx_byte = r_sp1;
      4'd2:    w_tx_byte = 8'h4B;
      4'd3:    w_tx_byte = 8'h46;
      4'd4:    w_tx_byte = 8'h7F;
      4'd5:    w_tx_byte = 8'hFF;
      4'd6:    w_tx_byte = 8'h0C;
      4'd7:    w_tx_byte = 8'h10;
      default: w_tx_byte = w_byte8;
    endcase
  end

  assign w_tx_bit = w_tx_byte[r_bit];

`ifdef VOUT_DS18B20_CRC_EN
  logic [7:0] r_crc;
  logic       w_crc_fb;

  assign w_crc_fb = r_crc[0] ^ w_tx_bit;
  assign w_byte8  = r_crc;

  // Accumulates over bytes 0-7 as they leave; cleared whenever not transmitting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_crc <= '0;
    else if (r_state != S_TX)              r_crc <= '0;
    else if (w_slot_end && r_byte != 4'd8) r_crc <= {1'b0, r_crc[7:1]} ^ (w_crc_fb ? 8'h8C : 8'h00);
  end
`else
  assign w_byte8 = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_us     <= '0;
      r_slot   <= 1'b0;
      r_drive  <= 1'b0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_shift  <= '0;
      r_sp0    <= 8'h50;
      r_sp1    <= 8'h05;
      last_cmd <= 8'h00;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (w_bus_reset) begin
        r_state <= S_PRES_WAIT;
        r_us    <= '0;
        r_slot  <= 1'b0;
        r_drive <= 1'b0;
      end else begin
        case (r_state)
          S_PRES_WAIT: if (w_us_tick) begin
            if (r_us == 7'd29) begin
              r_us    <= '0;
              r_drive <= 1'b1;
              r_state <= S_PRES;
            end else r_us <= r_us + 7'd1;
          end
          S_PRES: if (w_us_tick) begin
            if (r_us == 7'd119) begin
              r_us    <= '0;
              r_drive <= 1'b0;
              r_slot  <= 1'b0;
              r_bit   <= '0;
              r_state <= S_RX_ROM;
            end else r_us <= r_us + 7'd1;
          end
          S_RX_ROM, S_RX_FUNC: begin
            if (!r_slot) begin
              if (w_fall && !r_drive) begin
                r_slot <= 1'b1;
                r_us   <= '0;
              end
            end else if (w_slot_end) begin
              r_slot  <= 1'b0;
              r_shift <= w_rx_byte;
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                if (r_state == S_RX_ROM) begin
                  if (w_rx_byte == 8'hCC) r_state <= S_RX_FUNC;
                  else begin
                    cmd_err <= 1'b1;
                    r_state <= S_IDLE;
                  end
                end else begin
                  case (w_rx_byte)
                    8'h44: begin
                      last_cmd <= 8'h44;
                      r_sp0    <= temperature[7:0];
                      r_sp1    <= temperature[15:8];
                      r_state  <= S_CONV;
                    end
                    8'hBE: begin
                      last_cmd <= 8'hBE;
                      r_byte   <= '0;
                      r_state  <= S_TX;
                    end
                    default: begin
                      cmd_err <= 1'b1;
                      r_state <= S_IDLE;
                    end
                  endcase
                end
              end
            end else if (w_us_tick) r_us <= r_us + 7'd1;
          end
          S_TX: begin
            if (!r_slot) begin
              if (w_fall && !r_drive) begin
                r_slot  <= 1'b1;
                r_us    <= '0;
                r_drive <= ~w_tx_bit;
              end
            end else if (w_slot_end) begin
              r_slot  <= 1'b0;
              r_drive <= 1'b0;
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                if (r_byte == 4'd8) r_state <= S_IDLE;
                else                r_byte  <= r_byte + 4'd1;
              end
            end else if (w_us_tick) r_us <= r_us + 7'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vout_ds18b20.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_vout_ds18b20                                           |
// | Purpose  : Bus-master bench with protocol-level model of vout_ds18b20 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_vout_ds18b20;

  localparam int TICK_DIV = 2;
  localparam int US       = TICK_DIV * 10;

  localparam logic [1:0] D_NO = 2'd0, D_YES = 2'd1, D_DC = 2'd2;
  localparam int PH_NONE = 0, PH_ROM = 1, PH_FUNC = 2, PH_CONV = 3, PH_READ = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] temperature = 16'sd0;
  logic [7:0]         last_cmd;
  logic               cmd_err;
  wire                one_wire;
  logic               m_drive = 1'b0;

  assign one_wire = m_drive ? 1'b0 : 1'bz;
  pullup pu (one_wire);

  vout_ds18b20 #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .one_wire   (one_wire),
    .temperature(temperature),
    .last_cmd   (last_cmd),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         err_cycles = 0;
  logic [1:0] exp_drive = D_NO;
  logic       err_ok = 1'b0;
  logic       lc_dc  = 1'b0;
  logic [7:0] m_last = 8'h00;
  logic [15:0] m_scratch = 16'h0550;
  int         m_phase = PH_NONE;
  int         m_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  function automatic logic [7:0] dallas_crc(input logic [63:0] data, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n * 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) c = (c >> 1) ^ 8'h8C;
      else                          c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [7:0] model_byte(input int k);
    logic [7:0] t [9];
    t[0] = m_scratch[7:0];  t[1] = m_scratch[15:8];
    t[2] = 8'h4B; t[3] = 8'h46; t[4] = 8'h7F; t[5] = 8'hFF; t[6] = 8'h0C; t[7] = 8'h10;
`ifdef VOUT_DS18B20_CRC_EN
    t[8] = dallas_crc({t[7], t[6], t[5], t[4], t[3], t[2], t[1], t[0]}, 8);
`else
    t[8] = 8'h00;
`endif
    return t[k];
  endfunction

  function automatic logic exp_rd_bit();
    logic [7:0] bv;
    if (m_phase != PH_READ) return 1'b1;
    bv = model_byte(m_idx / 8);
    return bv[m_idx % 8];
  endfunction

  function automatic logic model_err(input logic [7:0] v);
    return (m_phase == PH_ROM && v != 8'hCC) ||
           (m_phase == PH_FUNC && v != 8'h44 && v != 8'hBE);
  endfunction

  task automatic model_apply(input logic [7:0] v);
    if (m_phase == PH_ROM) begin
      m_phase = (v == 8'hCC) ? PH_FUNC : PH_NONE;
    end else if (m_phase == PH_FUNC) begin
      if (v == 8'h44) begin
        m_last = 8'h44; m_scratch = temperature; m_phase = PH_CONV;
      end else if (v == 8'hBE) begin
        m_last = 8'hBE; m_idx = 0; m_phase = PH_READ;
      end else m_phase = PH_NONE;
    end
  endtask

  task automatic bus_reset();
    exp_drive = D_NO;
    m_drive = 1'b1; #(500*US); m_drive = 1'b0;
    m_phase = PH_ROM;
    #(28*US); exp_drive = D_DC;
    #(5*US);  exp_drive = D_YES;
    #(55*US); chk("presence", one_wire, 1'b0);
    #(60*US); exp_drive = D_DC;
    #(6*US);  exp_drive = D_NO;
    #(8*US);
  endtask

  task automatic write_bit(input logic b);
    exp_drive = D_NO;
    m_drive = 1'b1;
    if (b) begin #(5*US);  m_drive = 1'b0; #(60*US); end
    else   begin #(60*US); m_drive = 1'b0; #(5*US);  end
  endtask

  task automatic write_byte(input logic [7:0] v);
    int   e0;
    logic ee;
    ee = model_err(v);
    e0 = err_cycles;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin lc_dc = 1'b1; err_ok = ee; end
      write_bit(v[i]);
    end
    model_apply(v);
    lc_dc = 1'b0; err_ok = 1'b0;
    chk("cmd_err_pulse_len", err_cycles - e0, ee ? 1 : 0);
  endtask

  task automatic read_bit(output logic b);
    logic eb;
    eb = exp_rd_bit();
    m_drive = 1'b1;
    #(2*US);  m_drive = 1'b0; exp_drive = eb ? D_NO : D_YES;
    #(13*US); b = one_wire;
    #(13*US); exp_drive = D_DC;
    #(5*US);  exp_drive = D_NO;
    #(32*US);
    if (m_phase == PH_READ) begin
      m_idx++;
      if (m_idx == 72) m_phase = PH_NONE;
    end
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  // Per-cycle comparison of all outputs against the protocol model
  always @(negedge clk) begin
    if (!reset_n) begin
      if (!m_drive) chk("reset_line_z", one_wire, 1'b1);
      chk("reset_last_cmd", last_cmd, 8'h00);
      chk("reset_cmd_err", cmd_err, 1'b0);
    end else begin
      if (!m_drive && exp_drive == D_NO)  chk("no_drive", one_wire, 1'b1);
      if (!m_drive && exp_drive == D_YES) chk("drive_low", one_wire, 1'b0);
      if (cmd_err) err_cycles++;
      if (!err_ok) chk("cmd_err_quiet", cmd_err, 1'b0);
      if (!lc_dc)  chk("last_cmd", last_cmd, m_last);
    end
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] bad;
    logic       b;

    chk("crc_model_an27", dallas_crc(64'h0000_0000_01B8_1C02, 7), 8'hA2);
    chk("crc_model_zero", dallas_crc(64'h0, 8), 8'h00);

    repeat (5) @(posedge clk);
    #2; reset_n = 1'b1;
    #(10*US);

    // Presence from IDLE, then read scratchpad with power-on contents
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int k = 0; k < 9; k++) begin
      read_byte(v);
      chk("read_default", v, model_byte(k));
      if (k == 0) chk("default_byte0", v, 8'h50);
      if (k == 1) chk("default_byte1", v, 8'h05);
      if (k == 7) chk("default_byte7", v, 8'h10);
    end
    read_bit(b);
    chk("idle_after_72", b, 1'b1);

    // Convert with a known temperature; input changes afterwards must not leak in
    temperature = 16'sh0191;
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'h44);
    temperature = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      read_bit(b);
      chk("conv_slot_one", b, 1'b1);
    end
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int k = 0; k < 4; k++) begin
      read_byte(v);
      chk("read_conv", v, model_byte(k));
      if (k == 0) chk("conv_byte0", v, 8'h91);
      if (k == 1) chk("conv_byte1", v, 8'h01);
      if (k == 3) chk("conv_byte3", v, 8'h46);
    end
    chk("last_cmd_be", last_cmd, 8'hBE);

    // Unsupported ROM command
    bus_reset();
    write_byte(8'h33);
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      chk("bad_rom_slot_one", b, 1'b1);
    end

    // Abort a read after 20 bits with a bus reset
    temperature = 16'($urandom);
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'h44);
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 20; i++) begin
      b = exp_rd_bit();
      v[0] = b;
      read_bit(b);
      chk("partial_read_bit", b, v[0]);
    end
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int k = 0; k < 2; k++) begin
      read_byte(v);
      chk("restart_byte", v, model_byte(k));
    end

    // Randomized temperatures and bad function commands
    for (int it = 0; it < 2; it++) begin
      temperature = 16'($urandom);
      bad = 8'($urandom_range(0, 255));
      if (bad == 8'h44 || bad == 8'hBE) bad = 8'h48;
      bus_reset();
      write_byte(8'hCC);
      write_byte(bad);
      bus_reset();
      write_byte(8'hCC);
      write_byte(8'h44);
      bus_reset();
      write_byte(8'hCC);
      write_byte(8'hBE);
      for (int k = 0; k < ((it == 0) ? 9 : 2); k++) begin
        read_byte(v);
        chk("read_random", v, model_byte(k));
      end
    end

    // reset_n asserted while the block is driving a 0 bit
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 40 && exp_rd_bit() == 1'b1; i++) begin
      read_bit(b);
      chk("pre_reset_bit", b, 1'b1);
    end
    m_drive = 1'b1;
    #(2*US); m_drive = 1'b0; exp_drive = D_YES;
    #(10*US);
    chk("driving_before_reset", one_wire, 1'b0);
    exp_drive = D_DC;
    reset_n = 1'b0;
    m_last = 8'h00; m_scratch = 16'h0550; m_phase = PH_NONE;
    #1;
    chk("async_release", one_wire, 1'b1);
    chk("async_last_cmd", last_cmd, 8'h00);
    repeat (4) @(posedge clk);
    #2; reset_n = 1'b1; exp_drive = D_NO;
    #(10*US);
    chk("last_cmd_after_reset", last_cmd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
